// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode constants: opcode classes, NOP word, pcInMux_ctrl encodings, fetch FSM states.
package instr_fetch_unit_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h7F80;

    localparam logic [1:0] PC_SEQ    = 2'b11;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_RESET  = 2'b10;

    // OP_s classes as seen by the control-LUT decoder
    localparam logic [3:0] OPS_ALU    = 4'h0;
    localparam logic [3:0] OPS_LOAD   = 4'h1;
    localparam logic [3:0] OPS_STORE  = 4'h2;
    localparam logic [3:0] OPS_BRANCH = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic is_redirect(input logic [1:0] sel);
        return sel != PC_SEQ;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry prefetch FIFO with flush; head is registered (data visible the cycle after push).
// Push+pop while full is legal; pop while empty is ignored; caller must never push while full without popping.
module fetch_queue #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_head_dat,
    output logic         o_head_vld,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [0:1];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;

    assign w_do_pop   = i_pop & (r_count != 2'd0);
    assign o_head_vld = (r_count != 2'd0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_do_pop};
        end
    end

    // When full, push and pop hit the same slot: the head is read out before it is overwritten.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-memory fetcher with 2-deep prefetch; word shows on instruction one cycle after pm_ack, 1 instr/cycle sustained.
// Requests only while queue+outstanding < 2; redirects flush the queue and drain any in-flight read.
module instr_fetch_unit #(
    parameter int                PC_W      = 12,
    parameter logic [PC_W-1:0]   RESET_VEC = '0,
    parameter logic [15:0]       NOP_INSTR = instr_fetch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            pm_req,
    output logic [PC_W-1:0] pm_addr,
    input  logic            pm_ack,
    input  logic [15:0]     pm_rdata,
    output logic [15:0]     instruction,
    output logic [7:0]      OP_dk,
    output logic [3:0]      OP_s,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic [1:0]      pcInMux_ctrl,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] fetch_pc
);
    import instr_fetch_unit_pkg::*;

    localparam int QW = 16 + PC_W;

    fetch_state_t    r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_drain_addr, w_drain_addr_nxt;
    logic [PC_W-1:0] w_redirect_pc;
    logic [PC_W-1:0] w_head_pc;
    logic [QW-1:0]   w_head_dat;
    logic            w_head_vld;
    logic [1:0]      w_count, w_count_nxt;
    logic            w_consume, w_redirect, w_push, w_pop, w_slot_free;

    fetch_queue #(.W(QW)) u_fetch_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_push_dat ({pm_rdata, r_pc}),
        .i_pop      (w_pop),
        .i_flush    (w_redirect),
        .o_head_dat (w_head_dat),
        .o_head_vld (w_head_vld),
        .o_count    (w_count)
    );

    assign w_head_pc   = w_head_dat[PC_W-1:0];
    assign w_consume   = w_head_vld & instr_ready;
    assign w_redirect  = w_consume & is_redirect(pcInMux_ctrl);
    // A word acked alongside a redirect belongs to the wrong path and is dropped.
    assign w_push      = (r_state == ST_REQ) & pm_ack & ~w_redirect;
    assign w_pop       = w_consume & ~w_redirect;
    assign w_count_nxt = w_redirect ? 2'd0 : (w_count + {1'b0, w_push} - {1'b0, w_pop});
    assign w_slot_free = (w_count_nxt < 2'd2);

    always_comb begin
        w_redirect_pc = RESET_VEC;
        case (pcInMux_ctrl)
            PC_BRANCH: w_redirect_pc = branch_target;
            PC_HOLD:   w_redirect_pc = w_head_pc;
            default:   w_redirect_pc = RESET_VEC;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        case (r_state)
            ST_IDLE: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = ST_REQ;
                end else if (w_slot_free) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_redirect) begin
                    w_pc_nxt = w_redirect_pc;
                    if (!pm_ack) begin
                        w_state_nxt      = ST_DRAIN;
                        w_drain_addr_nxt = r_pc;
                    end
                end else if (pm_ack) begin
                    w_pc_nxt    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    w_state_nxt = w_slot_free ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pm_ack)
                    w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_VEC;
            r_drain_addr <= RESET_VEC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
        end
    end

    // The abandoned read keeps its own address so pm_addr stays stable until its ack.
    assign pm_req      = (r_state != ST_IDLE);
    assign pm_addr     = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
    assign instr_valid = w_head_vld;
    assign instruction = w_head_vld ? w_head_dat[QW-1:PC_W] : NOP_INSTR;
    assign OP_dk       = instruction[15:8];
    assign OP_s        = instruction[15:12];
    assign fetch_pc    = w_head_vld ? w_head_pc : r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: driver models the architectural PC stream, monitor checks each presented instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pm_req;
    logic [11:0] pm_addr;
    logic        pm_ack;
    logic [15:0] pm_rdata;
    logic [15:0] instruction;
    logic [7:0]  OP_dk;
    logic [3:0]  OP_s;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pcInMux_ctrl;
    logic [11:0] branch_target;
    logic [11:0] fetch_pc;

    instr_fetch_unit #(.PC_W(12), .RESET_VEC(12'h000), .NOP_INSTR(16'h7F80)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pm_req        (pm_req),
        .pm_addr       (pm_addr),
        .pm_ack        (pm_ack),
        .pm_rdata      (pm_rdata),
        .instruction   (instruction),
        .OP_dk         (OP_dk),
        .OP_s          (OP_s),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pcInMux_ctrl  (pcInMux_ctrl),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc)
    );

    initial forever #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          consumes = 0;
    bit          run = 1'b0;
    bit          force_stall = 1'b0;
    bit          rand_mode = 1'b0;
    bit          br_pending = 1'b0;
    bit          hold_pending = 1'b0;
    logic [11:0] br_tgt = 12'h000;
    logic [11:0] hold_addr = 12'h000;
    logic [11:0] m_pc = 12'h000;
    int          mem_min = 0;
    int          mem_max = 0;
    logic [11:0] exp_q[$];

    function automatic logic [15:0] word_of(input logic [11:0] a);
        return {a[3:0] ^ a[11:8], a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program memory: fixed contents, per-request wait of mem_min..mem_max cycles.
    initial begin
        int          cnt;
        bit          busy;
        logic [11:0] held;
        cnt = 0; busy = 1'b0; held = 12'h000;
        pm_ack = 1'b0; pm_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (!pm_req) begin
                pm_ack = 1'b0;
                busy   = 1'b0;
            end else begin
                if (busy)
                    chk("pm_addr_stable", 32'(pm_addr), 32'(held));
                if (!busy) begin
                    busy = 1'b1;
                    held = pm_addr;
                    cnt  = $urandom_range(mem_max, mem_min);
                end
                if (cnt == 0) begin
                    pm_ack   = 1'b1;
                    pm_rdata = word_of(pm_addr);
                    busy     = 1'b0;
                end else begin
                    pm_ack   = 1'b0;
                    pm_rdata = 16'($urandom);
                    cnt--;
                end
            end
        end
    end

    // Decoder driver and architectural PC model: pushes the address expected next on every consume.
    initial begin
        logic [1:0] c;
        instr_ready = 1'b0; pcInMux_ctrl = 2'b11; branch_target = 12'h000;
        forever begin
            @(negedge clk);
            if (!run) begin
                instr_ready  = 1'b0;
                pcInMux_ctrl = 2'b11;
            end else begin
                instr_ready   = force_stall ? 1'b0 : (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
                c             = 2'b11;
                branch_target = 12'($urandom);
                if (rand_mode && $urandom_range(0, 7) == 0)
                    c = 2'($urandom_range(0, 2));
                if (br_pending) begin
                    c             = 2'b01;
                    branch_target = br_tgt;
                end else if (hold_pending && instr_valid && fetch_pc == hold_addr) begin
                    c = 2'b00;
                end
                pcInMux_ctrl = c;
                #1;
                if (instr_valid && instr_ready) begin
                    consumes++;
                    case (c)
                        2'b11:   m_pc = m_pc + 12'd1;
                        2'b01:   m_pc = branch_target;
                        2'b10:   m_pc = 12'h000;
                        default: m_pc = m_pc;
                    endcase
                    exp_q.push_back(m_pc);
                    if (c == 2'b01) br_pending = 1'b0;
                    if (c == 2'b00) hold_pending = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented head against the scoreboard front, pops on consume.
    initial begin
        int          stall_len;
        int          idle_len;
        bit          prev_stalled;
        logic [15:0] prev_instr;
        logic [11:0] e;
        logic [15:0] w;
        stall_len = 0; idle_len = 0; prev_stalled = 1'b0; prev_instr = 16'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!run) begin
                stall_len = 0; idle_len = 0; prev_stalled = 1'b0;
            end else begin
                if (prev_stalled)
                    chk("stall_stable", 32'(instruction), 32'(prev_instr));
                if (instr_valid) begin
                    idle_len = 0;
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_instr: got pc %0h, expected no valid head at %0t", fetch_pc, $time);
                    end else begin
                        e = exp_q[0];
                        w = word_of(e);
                        chk("fetch_pc", 32'(fetch_pc), 32'(e));
                        chk("instruction", 32'(instruction), 32'(w));
                        chk("OP_dk", 32'(OP_dk), 32'(w[15:8]));
                        chk("OP_s", 32'(OP_s), 32'(w[15:12]));
                        if (instr_ready) void'(exp_q.pop_front());
                    end
                    if (!instr_ready) begin
                        stall_len++;
                        if (mem_max == 0 && stall_len >= 3)
                            chk("full_no_req", 32'(pm_req), 32'(0));
                    end else begin
                        stall_len = 0;
                    end
                    prev_stalled = !instr_ready;
                    prev_instr   = instruction;
                end else begin
                    chk("nop_instr", 32'(instruction), 32'h7F80);
                    chk("nop_op_dk", 32'(OP_dk), 32'h7F);
                    chk("nop_op_s", 32'(OP_s), 32'h7);
                    stall_len = 0; prev_stalled = 1'b0;
                    idle_len++;
                    if (idle_len == 100) begin
                        vectors++; miscompares++;
                        $display("FAIL liveness: got 100 idle cycles, expected a valid instruction at %0t", $time);
                    end
                end
            end
        end
    end

    task automatic wait_valid_pc(input string name, input logic [11:0] exp);
        int t;
        t = 0;
        do begin
            @(negedge clk); #3; t++;
        end while (!instr_valid && t < 100);
        chk({name, "_valid"}, 32'(instr_valid), 32'(1));
        chk(name, 32'(fetch_pc), 32'(exp));
    endtask

    task automatic wait_flag(input int which, input string name);
        int t;
        t = 0;
        while ((which == 0 ? br_pending : hold_pending) && t < 400) begin
            @(negedge clk); #3; t++;
        end
        chk(name, 32'(which == 0 ? br_pending : hold_pending), 32'(0));
    endtask

    initial begin
        int gap;
        int t;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pm_req", 32'(pm_req), 32'(0));
        chk("rst_pm_addr", 32'(pm_addr), 32'(0));
        chk("rst_valid", 32'(instr_valid), 32'(0));
        chk("rst_instr", 32'(instruction), 32'h7F80);
        chk("rst_op_dk", 32'(OP_dk), 32'h7F);
        chk("rst_op_s", 32'(OP_s), 32'h7);
        chk("rst_fetch_pc", 32'(fetch_pc), 32'(0));

        repeat (3) @(negedge clk);
        #3;
        exp_q.delete(); exp_q.push_back(12'h000); m_pc = 12'h000;
        run = 1'b1; reset_n = 1'b1;

        // startup latency and sustained throughput with zero-wait memory
        @(negedge clk); #4 chk("startup_c1_valid", 32'(instr_valid), 32'(0));
        @(negedge clk); #4 chk("startup_c2_valid", 32'(instr_valid), 32'(1));
        gap = 0;
        repeat (16) begin
            @(negedge clk); #4;
            if (instr_valid) gap++;
        end
        chk("throughput", 32'(gap), 32'(16));

        // decoder stall
        @(negedge clk); #3 force_stall = 1'b1;
        repeat (5) @(negedge clk);
        #3 force_stall = 1'b0;
        repeat (10) @(negedge clk);

        // branch with a read in flight on slow memory
        #3; mem_min = 3; mem_max = 3; br_tgt = 12'h040; br_pending = 1'b1;
        wait_flag(0, "branch_taken");
        wait_valid_pc("branch_pc", 12'h040);
        repeat (20) @(negedge clk);

        // hold re-presents the word at 005
        #3; mem_min = 0; mem_max = 1; br_tgt = 12'h003; hold_addr = 12'h005;
        br_pending = 1'b1; hold_pending = 1'b1;
        wait_flag(1, "hold_taken");
        wait_valid_pc("hold_repeat", 12'h005);
        repeat (10) @(negedge clk);

        // PC wrap
        #3; mem_min = 0; mem_max = 0; br_tgt = 12'hFFD; br_pending = 1'b1;
        wait_flag(0, "wrap_branch_taken");
        t = 0;
        while (!(instr_valid && fetch_pc == 12'hFFF) && t < 50) begin
            @(negedge clk); #3; t++;
        end
        chk("wrap_reach_fff", 32'(fetch_pc), 32'hFFF);
        wait_valid_pc("wrap_to_000", 12'h000);
        repeat (10) @(negedge clk);

        // randomized traffic
        #3; rand_mode = 1'b1; mem_min = 0; mem_max = 3;
        repeat (3000) @(negedge clk);
        #3 rand_mode = 1'b0;
        repeat (10) @(negedge clk);

        // reset with one word queued and a read outstanding
        #3; force_stall = 1'b1; mem_min = 3; mem_max = 3;
        t = 0;
        do begin
            @(negedge clk); #3; t++;
        end while (!(pm_req && instr_valid && !pm_ack) && t < 200);
        chk("midreq_setup", 32'(pm_req && instr_valid && !pm_ack), 32'(1));
        run = 1'b0; reset_n = 1'b0;
        #1;
        chk("arst_pm_req", 32'(pm_req), 32'(0));
        chk("arst_pm_addr", 32'(pm_addr), 32'(0));
        chk("arst_valid", 32'(instr_valid), 32'(0));
        chk("arst_instr", 32'(instruction), 32'h7F80);
        chk("arst_fetch_pc", 32'(fetch_pc), 32'(0));
        exp_q.delete(); exp_q.push_back(12'h000); m_pc = 12'h000;
        force_stall = 1'b0; br_pending = 1'b0; hold_pending = 1'b0;
        mem_min = 0; mem_max = 0;
        repeat (2) @(negedge clk);
        #3; reset_n = 1'b1; run = 1'b1;
        wait_valid_pc("restart_pc", 12'h000);
        repeat (40) @(negedge clk);

        chk("consume_count_ok", 32'(consumes > 300), 32'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction/opcode interface. Fetches 16-bit words from program memory and buffers them in a 2-entry prefetch queue.
- Presents the head word to the control-LUT decoder as the full instruction, OP_dk = instr[15:8] and OP_s = instr[15:12].
- Owns the program counter and applies the decoder's pcInMux_ctrl select and branch redirects, squashing wrong-path fetches.

Parameters:
- PC_W, 12, program-address width.
- RESET_VEC, 0, PC value after reset.
- NOP_INSTR, 16'h7F80, word driven when no instruction is valid (matches no decoder entry).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pm_req  out  1  program-memory read request; held until pm_ack.
- pm_addr  out  PC_W  read address; stable while pm_req=1.
- pm_ack  in  1  one-cycle pulse; pm_rdata valid this cycle.
- pm_rdata  in  16  fetched word.
- instruction  out  16  head of queue, or NOP_INSTR when empty.
- OP_dk  out  8  instruction[15:8].
- OP_s  out  4  instruction[15:12].
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  decoder consumes head this cycle when valid&ready.
- pcInMux_ctrl  in  2  from decoder, sampled on consume: 2'b11 sequential; 2'b01 load branch_target; 2'b00 hold PC (repeat); 2'b10 load RESET_VEC.
- branch_target  in  PC_W  redirect address.
- fetch_pc  out  PC_W  address of the head instruction.

Behaviour:
- Async reset (reset_n=0):
  - PC = RESET_VEC; queue empty; state IDLE.
  - pm_req=0, pm_addr=RESET_VEC, instr_valid=0, instruction=NOP_INSTR, fetch_pc=RESET_VEC.
- State machine:
  - IDLE -> REQ when the queue has a free slot, counting the outstanding request.
  - REQ: pm_req=1, pm_addr=nxt_pc.
    - On pm_ack: push {pm_rdata, addr}; nxt_pc = addr+1 (wraps mod 2^PC_W).
    - Then go to REQ if a slot is still free, else IDLE.
  - DRAIN: entered on redirect while a request is outstanding. Keep pm_req=1 until pm_ack, discard that word, then go to REQ at the new PC.
- Redirect, on consume with pcInMux_ctrl != 2'b11:
  - Flush the queue in the same cycle (next cycle instr_valid=0).
  - nxt_pc = branch_target (01), consumed fetch_pc (00), or RESET_VEC (10).
- Consume with 2'b11: pop the head; no PC change.
- Queue depth 2:
  - Push and pop in the same cycle while full is legal; count is unchanged.
  - Push while full never occurs, because a request is issued only if count + outstanding < 2.
  - Pop while empty is ignored.
- Latency: the fetched word appears on instruction the cycle after pm_ack if the queue was empty (registered head). Zero-wait memory sustains 1 instr/cycle after a 2-cycle startup.
- Simultaneous pm_ack and redirect: the acked word is discarded; no DRAIN is needed; go to REQ at the new PC next cycle.
- OP_dk and OP_s are pure slices of instruction and are NOP-derived when invalid.
- Reset mid-request abandons the request. Memory must tolerate pm_req dropping without ack.

Decomposition:
- Shared package / define file: opcode constants already used by the decoder, NOP_INSTR, and PC_SEQ/PC_BRANCH/PC_HOLD/PC_RESET encodings of pcInMux_ctrl (2'b11/01/00/10).
- One sub-module: fetch_queue (2-entry FIFO with flush, simultaneous push/pop, count output).

Test Plan:
- Reset release, zero-wait memory returning addr as data, instr_ready=1 -> pm_addr 0,1,2,…; instruction 16'h0000,0001,… one per cycle after 2 cycles; OP_dk/OP_s match the slices.
- instr_ready=0 for 5 cycles -> at most 2 words queued; pm_req stays low when full; instruction stable at its value; no word lost or duplicated on resume.
- Consume with pcInMux_ctrl=2'b01, branch_target=12'h040, request outstanding with 3-cycle ack -> acked word dropped (DRAIN); next valid instruction comes from 12'h040; fetch_pc=12'h040.
- pcInMux_ctrl=2'b00 on the word at 12'h005 -> the same word at 12'h005 is re-presented next.
- PC at 12'hFFF sequential -> next pm_addr=12'h000.
- Assert reset_n low mid-request with queue holding 1 word -> outputs return to reset values asynchronously; fetching restarts at RESET_VEC.
